// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding,
// operand/result bundles and a modulo index helper for the picker.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_LUI = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_EXEC = S_EXEC,
        ST_RESP = S_RESP
    } state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } alu_rsp_t;

    // (base + off) mod n, for base < n and off < n
    function automatic int wrap_idx(input int base, input int off,
                                    input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
// Ports: op_i opcode, a_i/b_i operands, res_o result,
//        zero_o (res_o == 0), ovf_o (unsigned carry of ADD).
module alu
    import alu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_o,
    output logic        zero_o,
    output logic        ovf_o
);

    logic [31:0] sum;
    logic [31:0] res;
    logic        ovf;

    assign sum = a_i + b_i;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (op_i)
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_ADD: begin
                res = sum;
                // a wrapped sum smaller than an addend means carry-out
                ovf = (sum < b_i);
            end
            OP_XOR: res = a_i ^ b_i;
            OP_NOR: res = ~(a_i | b_i);
            OP_LUI: res = {b_i[15:0], 16'h0000};
            OP_SUB: res = a_i - b_i;
            OP_SLT: res = {31'd0, (a_i < b_i)};
            default: res = '0;
        endcase
    end

    assign res_o  = res;
    assign zero_o = ~|res;
    assign ovf_o  = ovf;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or
// above ptr_i, wrapping. Ports: req_i, ptr_i in; gnt_o one-hot,
// idx_o winner index, any_o set when some request is present.
module rr_pick
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [ID_W-1:0] cand;

    // Scan from farthest offset down so the nearest one wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'(wrap_idx(int'(ptr_i), k, N_REQ));
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters, one op in flight.
// Ports: req_valid/req_ready/req_op/req_a/req_b per requester,
//        rsp_valid/rsp_ready/rsp_id/rsp_res/rsp_zero/rsp_ovf, busy.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [3*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_res,
    output logic                  rsp_zero,
    output logic                  rsp_ovf,
    output logic                  busy
);

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    alu_req_t        req_q;
    alu_req_t        req_d;
    logic [ID_W-1:0] id_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    alu_rsp_t        rsp_q;
    logic            busy_q;

    logic [2:0]  op_arr [N_REQ];
    logic [31:0] a_arr  [N_REQ];
    logic [31:0] b_arr  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[3*g +: 3];
        assign a_arr[g]  = req_a[32*g +: 32];
        assign b_arr[g]  = req_b[32*g +: 32];
    end

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_ovf;

    alu u_alu (
        .op_i   (req_q.op),
        .a_i    (req_q.a),
        .b_i    (req_q.b),
        .res_o  (alu_res),
        .zero_o (alu_zero),
        .ovf_o  (alu_ovf)
    );

    // Grants are only offered while idle; every grant is a handshake
    // because the picker only selects asserted valids.
    assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

    assign req_d.op = op_arr[pick_idx];
    assign req_d.a  = a_arr[pick_idx];
    assign req_d.b  = b_arr[pick_idx];

    assign rr_ptr_d = (pick_idx == ID_W'(N_REQ - 1)) ? '0
                                                     : pick_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            req_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        req_q    <= req_d;
                        id_q     <= pick_idx;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_q.res   <= alu_res;
                    rsp_q.zero  <= alu_zero;
                    rsp_q.ovf   <= alu_ovf;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_q.res;
    assign rsp_zero  = rsp_q.zero;
    assign rsp_ovf   = rsp_q.ovf;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a driver models arbitration and
// ALU results, a negedge monitor pops and checks responses.
module tb_alu_arbiter;

    localparam int N = 2;
    localparam int W = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [3*N-1:0]  req_op = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [W-1:0]    rsp_id;
    logic [31:0]     rsp_res;
    logic            rsp_zero;
    logic            rsp_ovf;
    logic            busy;

    alu_arbiter #(.N_REQ(N), .ID_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        longint      due;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;
    bit done = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [32:0] wide;
        e.id  = id;
        e.ovf = 1'b0;
        e.due = 0;
        case (op)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: begin
                wide  = {1'b0, a} + {1'b0, b};
                e.res = wide[31:0];
                e.ovf = wide[32];
            end
            3'd3: e.res = a ^ b;
            3'd4: e.res = ~(a | b);
            3'd5: e.res = b * 32'd65536;
            3'd6: e.res = a - b;
            default: e.res = (a < b) ? 32'd1 : 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Stimulus state applied by step()
    logic [N-1:0] t_v = '0;
    logic         t_rr = 1'b1;
    logic [2:0]   t_op [N];
    logic [31:0]  t_a  [N];
    logic [31:0]  t_b  [N];

    // Reference arbitration state
    int     m_ptr = 0;
    bit     m_busy = 0;
    longint m_due = 0;

    // Grants observed on the DUT (fairness check)
    bit     g_rec = 0;
    longint g_cyc[$];
    int     g_id[$];

    task automatic step();
        int win;
        logic [N-1:0] er;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = t_v;
        rsp_ready = t_rr;
        for (int i = 0; i < N; i++) begin
            req_op[3*i +: 3] = t_op[i];
            req_a[32*i +: 32] = t_a[i];
            req_b[32*i +: 32] = t_b[i];
        end
        #1;
        win = -1;
        er = '0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && t_v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(m_busy));
        if (g_rec && req_ready != '0) begin
            g_cyc.push_back(cyc);
            g_id.push_back(req_ready[1] ? 1 : 0);
        end
        if (win >= 0) begin
            e = model(win, t_op[win], t_a[win], t_b[win]);
            e.due = cyc + 2;
            sb.push_back(e);
            m_ptr = (win + 1) % N;
            m_busy = 1;
            m_due = cyc + 2;
        end else if (m_busy && cyc >= m_due && t_rr) begin
            m_busy = 0;
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        t_v = '0;
        sb.delete();
        m_ptr = 0;
        m_busy = 0;
        #1;
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst rsp_id", 64'(rsp_id), 64'd0);
        chk("rst rsp_res", 64'(rsp_res), 64'd0);
        chk("rst rsp_zero", 64'(rsp_zero), 64'd0);
        chk("rst rsp_ovf", 64'(rsp_ovf), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        repeat (ncyc) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        t_v = '0;
        t_rr = 1'b1;
        for (int i = 0; i < 12 && (m_busy || sb.size() > 0); i++) step();
        chk("drain sb empty", 64'(sb.size()), 64'd0);
        if (sb.size() > 0) sb.delete();
        m_busy = 0;
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        t_op[i] = op;
        t_a[i] = a;
        t_b[i] = b;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h1;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Response monitor
    logic ev;
    always @(negedge clk) begin
        if (!done) begin
            if (!rst_n) begin
                chk("rsp_valid in reset", 64'(rsp_valid), 64'd0);
            end else begin
                ev = (sb.size() > 0) && (cyc >= sb[0].due);
                chk("rsp_valid", 64'(rsp_valid), 64'(ev));
                if (rsp_valid && sb.size() > 0) begin
                    chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                    chk("rsp_res", 64'(rsp_res), 64'(sb[0].res));
                    chk("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
                    chk("rsp_ovf", 64'(rsp_ovf), 64'(sb[0].ovf));
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 3'd0, 32'd0, 32'd0);
        do_reset(2);

        // single request, ADD 5+3
        set_req(0, 3'b010, 32'd5, 32'd3);
        t_v = 2'b01;
        step();
        t_v = '0;
        drain();

        // ADD carry out and zero, then SUB to zero
        set_req(1, 3'b010, 32'hFFFF_FFFF, 32'h1);
        t_v = 2'b10;
        step();
        t_v = '0;
        drain();
        set_req(0, 3'b110, 32'd7, 32'd7);
        t_v = 2'b01;
        step();
        t_v = '0;
        drain();

        // fairness from reset
        do_reset(1);
        set_req(0, 3'b010, 32'd10, 32'd1);
        set_req(1, 3'b011, 32'hAAAA_0000, 32'h0000_5555);
        g_cyc.delete();
        g_id.delete();
        g_rec = 1;
        t_v = 2'b11;
        t_rr = 1'b1;
        repeat (18) step();
        g_rec = 0;
        t_v = '0;
        drain();
        chk("fair grant count", 64'(g_id.size()), 64'd6);
        for (int i = 0; i < g_id.size(); i++) begin
            chk("fair order", 64'(g_id[i]), 64'(i % 2));
            if (i > 0) chk("fair interval", 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
        end

        // backpressure with a competing requester
        set_req(0, 3'b111, 32'd2, 32'd9);
        set_req(1, 3'b001, 32'h1234_0000, 32'h0000_5678);
        t_v = 2'b11;
        step();
        t_rr = 1'b0;
        repeat (7) step();
        t_rr = 1'b1;
        step();
        step();
        t_v = '0;
        drain();

        // reset during EXEC discards the op
        set_req(0, 3'b101, 32'd0, 32'h0000_ABCD);
        t_v = 2'b01;
        step();
        do_reset(2);
        t_rr = 1'b1;
        repeat (3) step();
        set_req(1, 3'b010, 32'd1, 32'd2);
        t_v = 2'b10;
        step();
        t_v = '0;
        drain();
        t_v = 2'b11;
        step();
        t_v = '0;
        drain();

        // opcode sweep
        for (int op = 0; op < 8; op++) begin
            int r;
            r = int'($urandom % N);
            set_req(r, 3'(op), 32'hF0F0_0000, 32'h0FF0_1234);
            t_v = '0;
            t_v[r] = 1'b1;
            step();
            t_v = '0;
            drain();
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            t_v = N'($urandom);
            for (int i = 0; i < N; i++)
                set_req(i, 3'($urandom), rand_opnd(), rand_opnd());
            t_rr = ($urandom % 4) != 0;
            step();
        end
        drain();

        repeat (2) @(posedge clk);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between N_REQ requesters over valid/ready request and response channels.
- Arbitration is round-robin, at most one operation in flight.
- Operands, opcode and results are all registered.
- Sits between the CPU-side datapath clients (e.g. main pipeline, address-gen unit) and the single ALU instance.

Parameters:
N_REQ, 2, number of requesters (2..4)
ID_W, 1, width of requester index; must equal clog2(N_REQ), minimum 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_op  in  3*N_REQ  ALU opcode per requester, requester i at [3i+2:3i]
req_a  in  32*N_REQ  operand A per requester
req_b  in  32*N_REQ  operand B per requester
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_id  out  ID_W  index of requester owning the response
rsp_res  out  32  ALU result
rsp_zero  out  1  result == 0
rsp_ovf  out  1  ALU overflow flag
busy  out  1  high in EXEC or RESP

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_zero=0, rsp_ovf=0, busy=0.
  - Internal operand/op registers are 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner is the first asserted req_valid, searching from index rr_ptr upward and wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally. All other req_ready bits are 0. req_ready is 0 in every state other than IDLE.
  - On a handshake (req_valid & req_ready): latch op/A/B/winner id, set rr_ptr=(winner+1) mod N_REQ, go to EXEC.
  - With no request, stay in IDLE and leave rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - ALU is driven from the latched registers.
  - res, zero and ovf are captured into the rsp_* registers, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0, go to IDLE. A new grant is possible no earlier than the following cycle.
- Latency and throughput:
  - Request accept to rsp_valid is 2 cycles.
  - Minimum issue interval is 3 cycles when rsp_ready is tied high.
- ALU opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 B<<16, 110 SUB, 111 SLT (unsigned A<B -> 1).
  - Undefined encodings are not possible (3 bits, all mapped).
- Flags:
  - ovf=1 only for op ADD when the 32-bit sum (wrapped) < B, i.e. unsigned carry-out. Otherwise 0.
  - zero=1 iff the 32-bit result is 0.
- Boundary conditions:
  - Requests arriving in EXEC/RESP are not accepted. Requesters must hold req_valid and operands until req_ready; operands are sampled only on the handshake cycle.
  - A requester dropping req_valid before grant is legal; it is simply not chosen.
  - Simultaneous requests are resolved strictly by rr_ptr order. No requester waits more than N_REQ-1 grants.
  - Reset asserted mid-operation (EXEC or RESP) aborts immediately: the response is discarded, rsp_valid=0, state IDLE, rr_ptr=0.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_LUI, OP_SUB, OP_SLT.
  - state encoding localparams S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2.
- Sub-modules:
  - Instantiates the existing alu block unchanged for computation.
  - One natural sub-module: rr_pick (combinational round-robin priority picker: req vector + ptr -> one-hot grant + index).

Test Plan:
1. Reset then single request: req_valid=01, op=010, A=32'h0000_0005, B=32'h0000_0003 -> req_ready[0] same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_res=8, rsp_zero=0, rsp_ovf=0.
2. ADD overflow and zero: requester 1, op=010, A=32'hFFFF_FFFF, B=32'h1 -> rsp_res=0, rsp_zero=1, rsp_ovf=1, rsp_id=1. SUB A=7, B=7 -> res=0, zero=1, ovf=0.
3. Fairness: both req_valid held high with rsp_ready=1 for 6 operations from reset -> grant order 0,1,0,1,0,1; one grant per 3 cycles.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid (op 111, A=2, B=9) -> rsp_res=1 held stable, req_ready=0 throughout, busy=1. Releasing rsp_ready lets the next grant occur on the following cycle.
5. Reset mid-op: assert rst_n=0 during EXEC (op 101, B=32'h0000_ABCD) -> rsp_valid=0 immediately, no response emitted after release. The next request from requester 1 is granted ahead of 0 only if 0 is idle (rr_ptr=0).
6. Opcode sweep: A=32'hF0F0_0000, B=32'h0FF0_1234, all 8 ops -> AND 32'h00F0_0000, OR 32'hFFF0_1234, XOR 32'hFF00_1234, NOR 32'h000F_EDCB, B<<16 32'h1234_0000, SLT 0.
